// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the compare arbiter: FSM state encoding,
// default requester count and pointer-width helper.
package cmp_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CMP  = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam int NREQ_DEFAULT = 4;
    localparam int PTR_W        = $clog2(NREQ_DEFAULT);

    // Pointer width for an arbitrary requester count (never below one bit).
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparator.sv
// Shared unsigned magnitude comparator: ge = A >= B while enabled, else 0.
module comparator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             En,
    output logic             ge
);

    assign ge = En & (A >= B);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1 (modulo NREQ). Returns a one-hot winner and its index.
module rr_pick
    import cmp_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [PW-1:0]   win_idx_o,
    output logic            any_o
);

    // Candidate indices in priority order: ptr+1, ptr+2, ..., ptr (wrapped).
    logic [PW-1:0] cand [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign cand[k] = PW'((int'(ptr_i) + k + 1) % NREQ);
    end

    logic found;

    // Walk the rotated candidate list and keep the first active requester.
    always_comb begin
        found     = 1'b0;
        win_oh_o  = '0;
        win_idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[cand[k]]) begin
                found               = 1'b1;
                win_oh_o[cand[k]]   = 1'b1;
                win_idx_o           = cand[k];
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that time-shares one comparator among NREQ requesters.
// One transaction takes IDLE(grant+latch) -> CMP(compare) -> RESP(done).
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = NREQ_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  ge
);

    localparam int PW = ptr_width(NREQ);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic              ge_q, ge_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;

    logic [WIDTH-1:0]  a_arr [NREQ];
    logic [WIDTH-1:0]  b_arr [NREQ];
    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     win_idx;
    logic              win_any;
    logic              cmp_en;
    logic              cmp_ge;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
        assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .A  (op_a_q),
        .B  (op_b_q),
        .En (cmp_en),
        .ge (cmp_ge)
    );

    // Next-state and datapath-capture decisions for the three-state sequencer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        ge_d    = ge_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cmp_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    gnt_d   = win_oh;
                    idx_d   = win_idx;
                    op_a_d  = a_arr[win_idx];
                    op_b_d  = b_arr[win_idx];
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                cmp_en  = 1'b1;
                ge_d    = cmp_ge;
                state_d = S_RESP;
            end
            S_RESP: begin
                // Winner becomes the lowest priority for the next round.
                ptr_d   = idx_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            idx_q   <= '0;
            ge_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            ge_q    <= ge_d;
        end
    end

    // Operand latches; only meaningful while a grant is held, so no reset.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_RESP);
    assign ge   = ge_q;

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares one unsigned `>=` comparator datapath among `NREQ` requesters. Each requester presents an operand pair and holds `req`. The block grants one requester at a time, latches its operands, and drives the comparator with enable asserted for one cycle. It then returns the registered result with a one-cycle `done` pulse. It sits between the processor's compare/branch-condition sources and the single `comparator` instance it owns.

## Interface
- `WIDTH`, 8: operand width in bits; passed to the comparator instance.
- `NREQ`, 4: number of requesters, 2..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: request per requester; level, held until `done`.
- `a_in` in NREQ*WIDTH: A operands, requester i at bits [i*WIDTH +: WIDTH].
- `b_in` in NREQ*WIDTH: B operands, same packing as `a_in`.
- `gnt` out NREQ: one-hot grant, registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; result valid for the granted requester.
- `ge` out 1: registered result, 1 when A >= B (unsigned); holds until the next capture.

## Operation
- FSM states: IDLE, CMP, RESP. Encoding is binary 2'b00/01/10; 2'b11 recovers to IDLE.
- IDLE, no `req` bit set: stay in IDLE.
- IDLE, any `req` bit set:
  - Pick the winner as the first set bit searching upward from `ptr+1` modulo NREQ.
  - Set `gnt` one-hot for the winner.
  - Latch `a_in`/`b_in` slices into `op_a`/`op_b`.
  - Go to CMP.
- CMP:
  - Drive the comparator with A=`op_a`, B=`op_b`, En=1.
  - Capture its output into `ge`.
  - Go to RESP.
- RESP:
  - `done`=1 and `gnt` stays asserted.
  - Set `ptr` to the winner index.
  - Go to IDLE.
  - `gnt` clears on the transition.
- Comparator En is 0 in IDLE and RESP, so its output is 0 there; `ge` is written only in CMP.
- `req` dropped after the grant is ignored: the transaction completes and `done` still pulses.
- `req` still high in the IDLE cycle after `done` counts as a new request. Other pending requesters win first because of the rotated priority.
- Operand changes after the latch cycle have no effect on the current transaction.

## Timing
- Reset values: `gnt`=0, `busy`=0, `done`=0, `ge`=0, state=IDLE, `ptr`=NREQ-1, so requester 0 has top priority.
- Cycle numbering, with `req` first sampled high at edge 0:
  - `gnt`/`busy` high after edge 0.
  - `ge` valid after edge 1.
  - `done` high after edge 1, for exactly one cycle.
  - `gnt` low after edge 2.
- Request-to-`done` latency: 2 cycles.
- Throughput: one compare per 3 cycles. Back-to-back grants are separated by one IDLE cycle.
- `rst` has priority over all state. Reset mid-transaction (CMP or RESP):
  - Abort.
  - No `done` pulse.
  - All outputs return to reset values on the next edge.
- Simultaneous requests: exactly one grant. `gnt` never has more than one bit set.
- Wrap-around: winner NREQ-1 makes requester 0 the next highest priority.

## Structure
- Shared package/include holds:
  - State constants `S_IDLE`, `S_CMP`, `S_RESP`.
  - Default `NREQ`.
  - `PTR_W` = clog2(NREQ).
- One sub-module, `rr_pick`: purely combinational. Inputs are `req` and `ptr`; outputs are a one-hot winner and its index.
- Instantiates the existing `comparator` (width=WIDTH) once, with En driven by the FSM.
- `op_a`, `op_b`, `ptr`, `ge` and `gnt` are plain registers; no other sub-modules.

## Test plan
- Single requester: `req`=4'b0001, A=8'h80, B=8'h7F → `gnt`=0001 after edge 0, `done` pulse after edge 1, `ge`=1. Then A=8'h05, B=8'h05 → `ge`=1. Then A=8'h00, B=8'hFF → `ge`=0.
- All four requesting continuously from reset → grants in order 0,1,2,3,0. Each `done` is 3 cycles apart, `gnt` is always one-hot, and each `ge` matches its own operand pair.
- Starvation check: hold requester 2 continuously while requester 0 toggles. After requester 2 is served, requester 0 is served before requester 2 again.
- Operand change after grant: requester 1 with A=8'h10, B=8'h20, then A=8'hFF after edge 0 → `ge`=0.
- Reset asserted in CMP → no `done` pulse, all outputs 0 next cycle. The next request from requester 3 alone is granted normally.
- Requester drops `req` the cycle after its grant → `done` still pulses once and the FSM returns to IDLE with `busy`=0.
